// File: rtl/gshare_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : gshare_update_queue
// Description : Ordered update queue feeding a GShare predictor. Accepts up
//               to two resolved branches per cycle (port a older than port b)
//               and drains one per cycle into the predictor update port.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_update_queue #(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_a,
  input  logic [PC_BITS-1:0]         pc_a,
  input  logic                       taken_a,
  input  logic                       valid_b,
  input  logic [PC_BITS-1:0]         pc_b,
  input  logic                       taken_b,
  output logic                       ready,
  input  logic                       hold,
  output logic                       Wr_En,
  output logic [PC_BITS-1:0]         Orig_PC,
  output logic                       is_Taken,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Highest occupancy at which a full pair still fits.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [PC_BITS-1:0] pc_mem_q    [DEPTH];
  logic               taken_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_err_q, drop_err_d;

  logic               not_empty;
  logic               deq;
  logic               acc_a, acc_b;
  logic [1:0]         n_enq;
  logic               wr0_en, wr1_en;
  logic [PC_BITS-1:0] wr0_pc;
  logic               wr0_taken;
  logic [PTR_W-1:0]   tail_p1;

  assign not_empty = (count_q != '0);
  assign ready     = (count_q <= READY_MAX);
  assign deq       = not_empty && !hold;
  assign tail_p1   = tail_q + PTR_W'(1);

  assign Wr_En    = deq;
  assign Orig_PC  = not_empty ? pc_mem_q[head_q]    : '0;
  assign is_Taken = not_empty ? taken_mem_q[head_q] : 1'b0;
  assign count    = count_q;
  assign drop_err = drop_err_q;

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    acc_a      = ready && valid_a;
    acc_b      = ready && valid_b;
    n_enq      = {1'b0, acc_a} + {1'b0, acc_b};
    // A lone b takes the tail slot; a pair puts a at tail and b behind it.
    wr0_en     = acc_a || acc_b;
    wr0_pc     = acc_a ? pc_a : pc_b;
    wr0_taken  = acc_a ? taken_a : taken_b;
    wr1_en     = acc_a && acc_b;
    tail_d     = tail_q + PTR_W'(n_enq);
    head_d     = deq ? head_q + PTR_W'(1) : head_q;
    count_d    = count_q + CNT_W'(n_enq) - CNT_W'(deq);
    drop_err_d = drop_err_q || (!ready && (valid_a || valid_b));
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && wr0_en) begin
      pc_mem_q[tail_q]    <= wr0_pc;
      taken_mem_q[tail_q] <= wr0_taken;
    end
    if (rst_n && wr1_en) begin
      pc_mem_q[tail_p1]    <= pc_b;
      taken_mem_q[tail_p1] <= taken_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_update_queue
// Description : Directed self-checking bench for gshare_update_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_update_queue;

  localparam int PC_BITS = 32;
  localparam int DEPTH   = 8;

  logic               clk;
  logic               rst_n;
  logic               valid_a, taken_a, valid_b, taken_b;
  logic [PC_BITS-1:0] pc_a, pc_b;
  logic               ready, hold, Wr_En, is_Taken, drop_err;
  logic [PC_BITS-1:0] Orig_PC;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  gshare_update_queue #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_a(valid_a), .pc_a(pc_a), .taken_a(taken_a),
    .valid_b(valid_b), .pc_b(pc_b), .taken_b(taken_b),
    .ready(ready), .hold(hold),
    .Wr_En(Wr_En), .Orig_PC(Orig_PC), .is_Taken(is_Taken),
    .count(count), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_a = 1'b0; valid_b = 1'b0;
    pc_a = '0; pc_b = '0; taken_a = 1'b0; taken_b = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] pa, input logic ta,
                           input logic [31:0] pb, input logic tb);
    valid_a = 1'b1; pc_a = pa; taken_a = ta;
    valid_b = 1'b1; pc_b = pb; taken_b = tb;
    step();
    idle_inputs();
  endtask

  task automatic push_a(input logic [31:0] pa, input logic ta);
    valid_a = 1'b1; pc_a = pa; taken_a = ta;
    step();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    hold  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    // Reset state
    check("rst_count", count, 0);
    check("rst_wren", Wr_En, 0);
    check("rst_ready", ready, 1);
    check("rst_drop", drop_err, 0);
    check("rst_pc", Orig_PC, 0);
    rst_n = 1'b1;

    // Single a enqueue, then drain
    push_a(32'h2B4, 1'b1);
    check("t1_wren", Wr_En, 1);
    check("t1_pc", Orig_PC, 32'h2B4);
    check("t1_tk", is_Taken, 1);
    check("t1_count", count, 1);
    step();
    check("t1_wren_after", Wr_En, 0);
    check("t1_count_after", count, 0);
    check("t1_pc_after", Orig_PC, 0);

    // Same-cycle pair keeps a before b
    push_pair(32'h100, 1'b1, 32'h104, 1'b0);
    check("t2_count0", count, 2);
    check("t2_wren0", Wr_En, 1);
    check("t2_pc0", Orig_PC, 32'h100);
    check("t2_tk0", is_Taken, 1);
    step();
    check("t2_count1", count, 1);
    check("t2_wren1", Wr_En, 1);
    check("t2_pc1", Orig_PC, 32'h104);
    check("t2_tk1", is_Taken, 0);
    step();
    check("t2_count2", count, 0);

    // Fill to full under hold, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_pair(32'h1000 + 32'(8*i), 1'b1, 32'h1004 + 32'(8*i), i[0]);
      check("t3_fill_count", count, 2*(i+1));
      check("t3_fill_ready", ready, (i < 3) ? 1 : 0);
    end
    check("t3_hold_wren", Wr_En, 0);
    check("t3_hold_pc", Orig_PC, 32'h1000);
    hold = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t3_drain_wren", Wr_En, 1);
      check("t3_drain_count", count, 8 - k);
      check("t3_drain_ready", ready, ((8 - k) <= 6) ? 1 : 0);
      check("t3_drain_pc", Orig_PC, 32'h1000 + 32'(4*k));
      check("t3_drain_tk", is_Taken, (k % 2 == 0) ? 1 : ((k / 2) % 2));
      step();
    end
    check("t3_empty_count", count, 0);
    check("t3_empty_wren", Wr_En, 0);
    check("t3_drop_clear", drop_err, 0);

    // Overflow attempt at count=7
    hold = 1'b1;
    for (int i = 0; i < 3; i++)
      push_pair(32'h2000 + 32'(8*i), 1'b0, 32'h2004 + 32'(8*i), 1'b1);
    push_a(32'h2018, 1'b1);
    check("t4_count7", count, 7);
    check("t4_ready7", ready, 0);
    push_a(32'hDEAD, 1'b0);
    check("t4_count_kept", count, 7);
    check("t4_drop_set", drop_err, 1);
    hold = 1'b0;
    #1;
    for (int k = 0; k < 7; k++) begin
      check("t4_drain_pc", Orig_PC, 32'h2000 + 32'(4*k));
      step();
    end
    check("t4_drained", count, 0);
    check("t4_drop_sticky", drop_err, 1);
    check("t4_empty_pc", Orig_PC, 0);
    do_reset();
    check("t4_drop_rst", drop_err, 0);

    // Continuous single enqueue across pointer wrap
    for (int i = 0; i < 3*DEPTH; i++) begin
      push_a(32'h3000 + 32'(4*i), i[0]);
      check("t5_count", count, 1);
      check("t5_wren", Wr_En, 1);
      check("t5_pc", Orig_PC, 32'h3000 + 32'(4*i));
      check("t5_tk", is_Taken, i[0]);
    end
    step();
    check("t5_end_count", count, 0);

    // Reset mid-operation discards queued entries
    hold = 1'b1;
    push_pair(32'h5000, 1'b1, 32'h5004, 1'b1);
    push_pair(32'h5008, 1'b1, 32'h500C, 1'b1);
    push_a(32'h5010, 1'b1);
    check("t6_count5", count, 5);
    hold = 1'b0;
    do_reset();
    check("t6_rst_count", count, 0);
    check("t6_rst_wren", Wr_En, 0);
    check("t6_rst_pc", Orig_PC, 0);
    push_a(32'h4444, 1'b0);
    check("t6_new_count", count, 1);
    check("t6_new_pc", Orig_PC, 32'h4444);
    step();
    check("t6_final_count", count, 0);
    check("t6_final_wren", Wr_En, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
